// File: rtl/csr_pkg.sv
// Shared CSR definitions: addresses, field positions, funct3 codes, sleep FSM states.
// Also holds the read-modify-write helper used by the CSR file.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_CYCLE    = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
  localparam logic [11:0] CSR_INSTRET  = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH = 12'hC82;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;
  localparam int MIP_MTIP       = 7;
  localparam int MIP_MEIP       = 11;

  localparam logic [31:0] MEPC_MASK = 32'hFFFF_FFFC;

  localparam logic [2:0] F3_RW  = 3'b001;
  localparam logic [2:0] F3_RS  = 3'b010;
  localparam logic [2:0] F3_RC  = 3'b011;
  localparam logic [2:0] F3_RWI = 3'b101;
  localparam logic [2:0] F3_RSI = 3'b110;
  localparam logic [2:0] F3_RCI = 3'b111;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_SLEEP = 1'b1
  } state_e;

  function automatic logic [31:0] csr_apply(input logic [2:0]  op,
                                            input logic [31:0] old_v,
                                            input logic [31:0] wd);
    case (op)
      F3_RW, F3_RWI: csr_apply = wd;
      F3_RS, F3_RSI: csr_apply = old_v | wd;
      F3_RC, F3_RCI: csr_apply = old_v & ~wd;
      default:       csr_apply = old_v;
    endcase
  endfunction

endpackage

// File: rtl/csr_irq_ctrl_if.sv
// Core-to-CSR/interrupt-controller signal bundle.
// slave is the controller's view, master is the pipeline's view.
interface csr_irq_ctrl_if;
  logic        stall;
  logic        csr_en;
  logic [2:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic [31:0] trap_pc;
  logic        is_mret;
  logic        is_wfi_inst;
  logic        inst_retire;
  logic        ext_irq;
  logic        timer_irq;
  logic        interrupt;
  logic        interrupt_re;
  logic        isWFI;
  logic [31:0] mtvec;
  logic [31:0] mepc;

  modport slave (
    input  stall, csr_en, csr_op, csr_addr, csr_wdata, trap_pc,
           is_mret, is_wfi_inst, inst_retire, ext_irq, timer_irq,
    output csr_rdata, interrupt, interrupt_re, isWFI, mtvec, mepc
  );

  modport master (
    output stall, csr_en, csr_op, csr_addr, csr_wdata, trap_pc,
           is_mret, is_wfi_inst, inst_retire, ext_irq, timer_irq,
    input  csr_rdata, interrupt, interrupt_re, isWFI, mtvec, mepc
  );
endinterface

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with enable; wraps to zero after all-ones.
// Count visible one cycle after the enabled edge.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_en,
  output logic [63:0] o_count
);

  logic [63:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= 64'd0;
    end else if (i_en) begin
      r_count <= r_count + 64'd1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/csr_irq_ctrl.sv
// Machine-mode CSR file with interrupt/MRET/WFI sequencing; reads and trap decision are combinational.
// stall freezes all architectural updates except mip sampling and mcycle.
module csr_irq_ctrl
  import csr_pkg::*;
#(
  parameter logic [31:0] MTVEC_BASE = 32'h0001_0000
) (
  input logic           clk,
  input logic           rst,
  csr_irq_ctrl_if.slave bus
);

  logic        r_mie;
  logic        r_mpie;
  logic        r_meie;
  logic        r_mtie;
  logic        r_meip;
  logic        r_mtip;
  logic [31:0] r_mepc;
  logic [31:0] r_wfi_pc;
  state_e      r_state;
  state_e      w_state_nxt;

  logic [63:0] w_mcycle;
  logic [63:0] w_minstret;
  logic [31:0] w_rdata;
  logic [31:0] w_wval;
  logic        w_pending;
  logic        w_irq;
  logic        w_mret;
  logic        w_csr_wr;
  logic        w_wfi_enter;
  logic        w_iswfi;

  assign w_pending = (r_meip & r_meie) | (r_mtip & r_mtie);
  assign w_irq     = r_mie & w_pending & ~bus.stall;
  assign w_mret    = bus.is_mret & ~bus.stall & ~w_irq;

  // Set/clear forms with a zero operand are pure reads and must not write.
  assign w_csr_wr  = bus.csr_en & ~bus.stall & ~w_irq &
                     ((bus.csr_op[1:0] == 2'b01) |
                      (bus.csr_op[1] & (bus.csr_wdata != 32'd0)));
  assign w_wval    = csr_apply(bus.csr_op, w_rdata, bus.csr_wdata);

  always_comb begin
    w_rdata = 32'd0;
    case (bus.csr_addr)
      CSR_MSTATUS: begin
        w_rdata[MSTATUS_MIE]                   = r_mie;
        w_rdata[MSTATUS_MPIE]                  = r_mpie;
        w_rdata[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
      end
      CSR_MIE: begin
        w_rdata[MIP_MEIP] = r_meie;
        w_rdata[MIP_MTIP] = r_mtie;
      end
      CSR_MTVEC:    w_rdata = MTVEC_BASE;
      CSR_MEPC:     w_rdata = r_mepc;
      CSR_MIP: begin
        w_rdata[MIP_MEIP] = r_meip;
        w_rdata[MIP_MTIP] = r_mtip;
      end
      CSR_CYCLE:    w_rdata = w_mcycle[31:0];
      CSR_CYCLEH:   w_rdata = w_mcycle[63:32];
      CSR_INSTRET:  w_rdata = w_minstret[31:0];
      CSR_INSTRETH: w_rdata = w_minstret[63:32];
      default:      w_rdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Wake on any enabled pending source even with MIE clear; the core then resumes after the WFI.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:   if (bus.is_wfi_inst && !bus.stall && !w_pending) w_state_nxt = ST_SLEEP;
      ST_SLEEP: if (w_pending) w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    w_iswfi     = (r_state == ST_SLEEP);
    w_wfi_enter = (r_state == ST_RUN) && (w_state_nxt == ST_SLEEP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mie    <= 1'b0;
      r_mpie   <= 1'b0;
      r_meie   <= 1'b0;
      r_mtie   <= 1'b0;
      r_meip   <= 1'b0;
      r_mtip   <= 1'b0;
      r_mepc   <= 32'd0;
      r_wfi_pc <= 32'd0;
    end else begin
      r_meip <= bus.ext_irq;
      r_mtip <= bus.timer_irq;
      if (w_irq) begin
        r_mepc <= ((r_state == ST_SLEEP) ? (r_wfi_pc + 32'd4) : bus.trap_pc) & MEPC_MASK;
        r_mpie <= r_mie;
        r_mie  <= 1'b0;
      end else begin
        if (w_mret) begin
          r_mie  <= r_mpie;
          r_mpie <= 1'b1;
        end else if (w_csr_wr && (bus.csr_addr == CSR_MSTATUS)) begin
          r_mie  <= w_wval[MSTATUS_MIE];
          r_mpie <= w_wval[MSTATUS_MPIE];
        end
        if (w_csr_wr && (bus.csr_addr == CSR_MEPC)) begin
          r_mepc <= w_wval & MEPC_MASK;
        end
      end
      if (w_csr_wr && (bus.csr_addr == CSR_MIE)) begin
        r_meie <= w_wval[MIP_MEIP];
        r_mtie <= w_wval[MIP_MTIP];
      end
      if (w_wfi_enter) begin
        r_wfi_pc <= bus.trap_pc;
      end
    end
  end

  csr_counter64 u_mcycle (
    .clk     (clk),
    .rst     (rst),
    .i_en    (1'b1),
    .o_count (w_mcycle)
  );

  csr_counter64 u_minstret (
    .clk     (clk),
    .rst     (rst),
    .i_en    (bus.inst_retire & ~bus.stall),
    .o_count (w_minstret)
  );

  assign bus.csr_rdata    = w_rdata;
  assign bus.interrupt    = w_irq;
  assign bus.interrupt_re = w_mret;
  assign bus.isWFI        = w_iswfi;
  assign bus.mtvec        = MTVEC_BASE;
  assign bus.mepc         = r_mepc;

endmodule
